// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : hazard_stall_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard/stall
//               controller: controller state encoding, the hard-wired zero
//               register index and the memory-wait counter width.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

    // Controller state: normal issue, frozen on data memory, or halted on
    // a memory timeout.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_t;

    // Register index 0 is hard-wired to zero and never carries a dependency.
    localparam int unsigned REG_ZERO = '0;

    // Width of the consecutive memory-wait cycle counter.
    localparam int unsigned WAIT_W = 12;

endpackage : hazard_stall_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : hazard_stall_ctrl_if
// Description : Bundle between the pipeline datapath and the hazard/stall
//               controller.
//               Datapath -> controller : id_rs, id_rt, id_use_rs, id_use_rt,
//                   id_ret, ex_rd, ex_rf_we, ex_mem_read, ex_branch_taken,
//                   mem_req, mem_ready
//               Controller -> datapath : pc_we, if_id_we, if_id_flush,
//                   id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we, halt_err,
//                   stall_cnt, flush_cnt
//               master = datapath side, slave = controller side.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    // Hazard sources
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_ret;
    logic [REG_W-1:0] ex_rd;
    logic             ex_rf_we;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    // Pipeline controls and status
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_we;
    logic             id_ex_flush;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             halt_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_ret,
               ex_rd, ex_rf_we, ex_mem_read, ex_branch_taken,
               mem_req, mem_ready,
        input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, mem_wb_we, halt_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_ret,
               ex_rd, ex_rf_we, ex_mem_read, ex_branch_taken,
               mem_req, mem_ready,
        output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, mem_wb_we, halt_err, stall_cnt, flush_cnt
    );

endinterface : hazard_stall_ctrl_if
`default_nettype wire

// File: rtl/hazard_stall_ctrl_sat_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sat_counter
// Description : W-bit up-counter that sticks at its all-ones value.
//               clk - clock, rst - synchronous active-high clear,
//               inc - count enable, q - current count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc,
    output logic [W-1:0]      q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : hazard_stall_ctrl
// Description : Pipeline sequencing controller for the 5-stage core. Produces
//               write-enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and
//               MEM/WB from the current hazard inputs and a small state
//               machine (RUN / MEM_WAIT / HALT).
//               clk - core clock, rst - synchronous active-high reset,
//               bus - hazard_stall_ctrl_if.slave carrying all hazard inputs,
//                     pipeline controls, halt_err and the perf counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_stall_ctrl_if.slave bus
);

    hz_state_t          state_q;
    hz_state_t          state_d;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [WAIT_W-1:0]  wait_cnt_d;

    logic               w_load_use;
    logic               w_mem_stall;
    logic               w_stall_inc;
    logic               w_flush_inc;

    logic               w_pc_we;
    logic               w_if_id_we;
    logic               w_if_id_flush;
    logic               w_id_ex_we;
    logic               w_id_ex_flush;
    logic               w_ex_mem_we;
    logic               w_mem_wb_we;

    // A load in EX whose result is needed by the ID instruction; the value is
    // only available after MEM, so ID must wait one cycle.
    assign w_load_use = bus.ex_mem_read && bus.ex_rf_we &&
                        (bus.ex_rd != REG_W'(REG_ZERO)) &&
                        ((bus.id_use_rs && (bus.id_rs == bus.ex_rd)) ||
                         (bus.id_use_rt && (bus.id_rt == bus.ex_rd)));

    assign w_mem_stall = bus.mem_req && !bus.mem_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;
        w_pc_we       = 1'b1;
        w_if_id_we    = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_we    = 1'b1;
        w_id_ex_flush = 1'b0;
        w_ex_mem_we   = 1'b1;
        w_mem_wb_we   = 1'b1;

        if (rst) begin
            // Hold every stage and keep bubbles flowing into IF/ID and ID/EX.
            state_d       = RUN;
            wait_cnt_d    = '0;
            w_pc_we       = 1'b0;
            w_if_id_we    = 1'b0;
            w_id_ex_we    = 1'b0;
            w_ex_mem_we   = 1'b0;
            w_mem_wb_we   = 1'b0;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else begin
            case (state_q)
                RUN, MEM_WAIT: begin
                    if ((state_q == MEM_WAIT) && !bus.mem_ready) begin
                        // Still waiting on data memory: freeze everything.
                        w_pc_we     = 1'b0;
                        w_if_id_we  = 1'b0;
                        w_id_ex_we  = 1'b0;
                        w_ex_mem_we = 1'b0;
                        w_mem_wb_we = 1'b0;
                        w_stall_inc = 1'b1;
                        wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
                        if (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)) begin
                            state_d = HALT;
                        end
                    end else begin
                        // Normal issue; the completing MEM_WAIT cycle lands
                        // here too so frozen branch/ret/load-use get acted on.
                        state_d    = RUN;
                        wait_cnt_d = '0;
                        if (w_mem_stall) begin
                            w_pc_we     = 1'b0;
                            w_if_id_we  = 1'b0;
                            w_id_ex_we  = 1'b0;
                            w_ex_mem_we = 1'b0;
                            w_mem_wb_we = 1'b0;
                            w_stall_inc = 1'b1;
                            wait_cnt_d  = WAIT_W'(1);
                            state_d     = (wait_cnt_d == WAIT_W'(MEM_TIMEOUT))
                                          ? HALT : MEM_WAIT;
                        end else if (bus.ex_branch_taken) begin
                            // Squash both younger instructions; PC takes the
                            // branch target.
                            w_if_id_flush = 1'b1;
                            w_id_ex_flush = 1'b1;
                            w_flush_inc   = 1'b1;
                        end else if (w_load_use) begin
                            // Hold PC and IF/ID, insert one bubble into ID/EX.
                            w_pc_we       = 1'b0;
                            w_if_id_we    = 1'b0;
                            w_id_ex_flush = 1'b1;
                            w_stall_inc   = 1'b1;
                        end else if (bus.id_ret) begin
                            // Drop the instruction fetched behind the return.
                            w_if_id_flush = 1'b1;
                            w_flush_inc   = 1'b1;
                        end
                    end
                end
                default: begin
                    // HALT (and the unused encoding) freeze the pipe until rst.
                    state_d     = HALT;
                    w_pc_we     = 1'b0;
                    w_if_id_we  = 1'b0;
                    w_id_ex_we  = 1'b0;
                    w_ex_mem_we = 1'b0;
                    w_mem_wb_we = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall_inc),
        .q   (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_flush_inc),
        .q   (bus.flush_cnt)
    );

    assign bus.pc_we       = w_pc_we;
    assign bus.if_id_we    = w_if_id_we;
    assign bus.if_id_flush = w_if_id_flush;
    assign bus.id_ex_we    = w_id_ex_we;
    assign bus.id_ex_flush = w_id_ex_flush;
    assign bus.ex_mem_we   = w_ex_mem_we;
    assign bus.mem_wb_we   = w_mem_wb_we;
    assign bus.halt_err    = (state_q == HALT) && !rst;

endmodule : hazard_stall_ctrl
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_hazard_stall_ctrl
// Description : Directed self-checking bench for hazard_stall_ctrl. A main
//               instance (MEM_TIMEOUT=4) and a narrow-counter instance
//               (CNT_W=2) see the same stimulus; expected control values are
//               queued when a step is driven and compared mid-cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) bus_m ();
    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(2))  bus_s ();

    hazard_stall_ctrl #(.REG_W(5), .CNT_W(16), .MEM_TIMEOUT(4)) u_main (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    hazard_stall_ctrl #(.REG_W(5), .CNT_W(2), .MEM_TIMEOUT(255)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    typedef struct packed {
        logic [4:0] we;   // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic [1:0] fl;   // {if_id_flush, id_ex_flush}
        logic       halt;
    } exp_t;

    exp_t sb[$];
    int   total     = 0;
    int   bad       = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;
    int   exp_sat   = 0;
    bit   chk_sat   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int rs, input int rt, input bit urs, input bit urt,
                         input bit ret, input int rd, input bit rfwe, input bit mrd,
                         input bit br, input bit mreq, input bit mrdy);
        bus_m.id_rs = 5'(rs);  bus_s.id_rs = 5'(rs);
        bus_m.id_rt = 5'(rt);  bus_s.id_rt = 5'(rt);
        bus_m.id_use_rs = urs; bus_s.id_use_rs = urs;
        bus_m.id_use_rt = urt; bus_s.id_use_rt = urt;
        bus_m.id_ret = ret;    bus_s.id_ret = ret;
        bus_m.ex_rd = 5'(rd);  bus_s.ex_rd = 5'(rd);
        bus_m.ex_rf_we = rfwe; bus_s.ex_rf_we = rfwe;
        bus_m.ex_mem_read = mrd;     bus_s.ex_mem_read = mrd;
        bus_m.ex_branch_taken = br;  bus_s.ex_branch_taken = br;
        bus_m.mem_req = mreq;        bus_s.mem_req = mreq;
        bus_m.mem_ready = mrdy;      bus_s.mem_ready = mrdy;
    endtask

    // One clock of a directed step: inputs already applied just after the
    // rising edge. Controls are checked mid-cycle, counters after the edge.
    task automatic step(input string tag, input logic [4:0] we, input logic [1:0] fl,
                        input logic halt, input bit s_inc, input bit f_inc, input bit clr);
        exp_t e;
        exp_t o;
        e.we   = we;
        e.fl   = fl;
        e.halt = halt;
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        chk({tag, "/we"}, 32'({bus_m.pc_we, bus_m.if_id_we, bus_m.id_ex_we,
                               bus_m.ex_mem_we, bus_m.mem_wb_we}), 32'(o.we));
        chk({tag, "/flush"}, 32'({bus_m.if_id_flush, bus_m.id_ex_flush}), 32'(o.fl));
        chk({tag, "/halt"}, 32'(bus_m.halt_err), 32'(o.halt));
        @(posedge clk);
        #1;
        if (clr) begin
            exp_stall = 0;
            exp_flush = 0;
            exp_sat   = 0;
        end else begin
            exp_stall += int'(s_inc);
            exp_flush += int'(f_inc);
            if (s_inc && (exp_sat < 3)) exp_sat++;
        end
        chk({tag, "/stall_cnt"}, 32'(bus_m.stall_cnt), 32'(exp_stall));
        chk({tag, "/flush_cnt"}, 32'(bus_m.flush_cnt), 32'(exp_flush));
        if (chk_sat) chk({tag, "/sat_cnt"}, 32'(bus_s.stall_cnt), 32'(exp_sat));
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset
        step("rst0", 5'b00000, 2'b11, 1'b0, 0, 0, 1);
        step("rst1", 5'b00000, 2'b11, 1'b0, 0, 0, 1);
        rst = 1'b0;
        step("idle", 5'b11111, 2'b00, 1'b0, 0, 0, 0);

        // Load-use on rs, on rt, and non-hazard variants
        drive(5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0);
        step("lu_rs", 5'b00111, 2'b01, 1'b0, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        step("lu_r0", 5'b11111, 2'b00, 1'b0, 0, 0, 0);
        drive(5, 7, 0, 1, 0, 7, 1, 1, 0, 0, 0);
        step("lu_rt", 5'b00111, 2'b01, 1'b0, 1, 0, 0);
        drive(7, 3, 0, 1, 0, 7, 1, 1, 0, 0, 0);
        step("lu_nouse", 5'b11111, 2'b00, 1'b0, 0, 0, 0);
        drive(5, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
        step("no_load", 5'b11111, 2'b00, 1'b0, 0, 0, 0);

        // Branch beats load-use; return; load-use beats return
        drive(5, 0, 1, 0, 0, 5, 1, 1, 1, 0, 0);
        step("br_lu", 5'b11111, 2'b11, 1'b0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step("ret", 5'b11111, 2'b10, 1'b0, 0, 1, 0);
        drive(5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0);
        step("ret_lu", 5'b00111, 2'b01, 1'b0, 1, 0, 0);

        // Memory wait holding a taken branch, then completion
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("mw1", 5'b00000, 2'b00, 1'b0, 1, 0, 0);
        step("mw2", 5'b00000, 2'b00, 1'b0, 1, 0, 0);
        step("mw3", 5'b00000, 2'b00, 1'b0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        step("mw_done", 5'b11111, 2'b11, 1'b0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("mem_hit", 5'b11111, 2'b00, 1'b0, 0, 0, 0);

        // Timeout into HALT
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("to1", 5'b00000, 2'b00, 1'b0, 1, 0, 0);
        step("to2", 5'b00000, 2'b00, 1'b0, 1, 0, 0);
        step("to3", 5'b00000, 2'b00, 1'b0, 1, 0, 0);
        step("to4", 5'b00000, 2'b00, 1'b0, 1, 0, 0);
        step("halt1", 5'b00000, 2'b00, 1'b1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("halt2", 5'b00000, 2'b00, 1'b1, 0, 0, 0);

        // Reset out of HALT
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_halt", 5'b00000, 2'b11, 1'b0, 0, 0, 1);
        rst = 1'b0;
        step("post_rst", 5'b11111, 2'b00, 1'b0, 0, 0, 0);

        // Saturation on the 2-bit counter instance
        chk_sat = 1'b1;
        drive(9, 0, 1, 0, 0, 9, 1, 1, 0, 0, 0);
        step("sat1", 5'b00111, 2'b01, 1'b0, 1, 0, 0);
        step("sat2", 5'b00111, 2'b01, 1'b0, 1, 0, 0);
        step("sat3", 5'b00111, 2'b01, 1'b0, 1, 0, 0);
        step("sat4", 5'b00111, 2'b01, 1'b0, 1, 0, 0);
        step("sat5", 5'b00111, 2'b01, 1'b0, 1, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl
`default_nettype wire
